uart_frame_receiver: RTL
========================

Name: uart_frame_receiver

Overview:
Parametrised successor to the current UART receive path, with runtime-configurable frame format. Supports data length 5..DATA_WIDTH, 1 or 2 stop bits, optional parity, and 3-sample majority voting per bit. Delivers each frame through a valid/ready output register with overrun reporting. Sits between the pad-side serial input and the system-side command/data consumer.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame (legal 5..9)
SYNC_STAGES, 2, flops in the serial_data input synchroniser (legal >= 2)

Ports:
clk  input  1  system master clock (oversampling clock)
reset  input  1  global asynchronous active-low reset
serial_data  input  1  asynchronous serial line, idle high
prescale  input  6  oversampling ratio: 8, 16 or 32; any other value is treated as 16
data_length  input  4  data bits per frame, 5..DATA_WIDTH; out-of-range values use DATA_WIDTH
parity_enable  input  1  1 = parity bit present after the data bits
parity_type  input  1  1 = odd, 0 = even
two_stop_bits  input  1  1 = two stop bits expected
rx_ready  input  1  consumer accepts rx_data this cycle
rx_data  output  DATA_WIDTH  received data, LSB-aligned, unused MSBs zero
rx_valid  output  1  rx_data and flags valid; held until accepted
parity_error  output  1  parity mismatch for the presented frame
frame_error  output  1  at least one stop bit sampled 0 for the presented frame
overrun_error  output  1  one-cycle pulse: completed frame dropped because output was full
break_detected  output  1  one-cycle pulse: line break detected (see Optional Feature)

Behaviour:
- Reset (async, active-low): FSM=IDLE, counters 0, synchroniser flops 1. Outputs: rx_data=0, rx_valid=0, parity_error=0, frame_error=0, overrun_error=0, break_detected=0. Reset mid-frame aborts the frame; nothing is delivered.
- serial_data passes SYNC_STAGES flops; all logic uses the synchronised bit (sd).
- Edge counter runs 0..P-1 per bit, P=effective prescale. Samples are taken at counts P/2-1, P/2, P/2+1; bit value = majority of 3. Decision is made at count P/2+1.
- Config (prescale, data_length, parity_enable, parity_type, two_stop_bits) is latched on IDLE->START; changes mid-frame are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, (WAIT_IDLE with macro).
- IDLE: sd==0 -> START, edge count=0.
- START: majority==0 at decision -> DATA at bit end; majority==1 -> IDLE immediately (glitch; no error, no output).
- DATA: LSB first, bit index 0..data_length-1. After the last bit go to PARITY if enabled, else STOP1.
- PARITY: error = (XOR of data bits ^ sampled bit) != parity_type.
- STOP1: at decision, frame_error |= (majority==0). If two_stop_bits, go to STOP2 at bit end; otherwise the frame completes at the decision point.
- STOP2: same check; the frame completes at the decision point.
- On completion, the FSM returns to IDLE on the same edge, giving half a bit of margin for the next start.
- Completion at cycle N, output empty or rx_ready=1 at N: rx_data/flags load and rx_valid=1 at N+1.
- Completion at cycle N, rx_valid=1 and rx_ready=0: frame dropped, output unchanged, overrun_error=1 for cycle N+1 only.
- Handshake: rx_valid&&rx_ready clears rx_valid next cycle unless a new frame loads in the same cycle. rx_data and flags stay stable while rx_valid=1 and rx_ready=0.

Optional Feature:
Macro UART_RX_BREAK_DETECT_EN.
- Defined: a frame whose data bits, parity bit (if enabled) and STOP1 all sample 0 is a break. No rx_valid is raised; break_detected pulses 1 cycle at the STOP1 decision. The FSM enters WAIT_IDLE and returns to IDLE only after a bit-majority of 1.
- Undefined: such a frame is delivered normally with rx_data=0 and frame_error=1. break_detected is tied 0 and no WAIT_IDLE state exists.

Test Plan:
- prescale=16, 8N1, send 0xA5, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, parity_error=0, frame_error=0.
- prescale=8, data_length=7, even parity, 2 stop bits, send 0x5A with wrong parity -> rx_data=0x5A, parity_error=1, frame_error=0. Repeat with STOP2=0 -> frame_error=1.
- prescale=32, start pulse low for 4 clocks only -> no rx_valid, FSM back in IDLE. Also: single-clock glitch inside a data bit at count P/2 -> still correct data (majority).
- rx_ready=0, send 0x11 then 0x22 -> rx_data holds 0x11, overrun_error pulses once. Set rx_ready=1 on the completion cycle of a third frame 0x33 -> 0x33 loaded, no overrun.
- Assert reset mid-DATA, release, send 0x3C -> only 0x3C is delivered. With UART_RX_BREAK_DETECT_EN, hold line low 12 bit times -> break_detected=1 once, no rx_valid; reception resumes after the line returns high.

Source files
------------

// File: rtl/uart_frame_receiver.sv
// -----------------------------------------------------------------------------
// uart_frame_receiver
//
// Purpose:
//   Receives asynchronous serial frames with a frame format that is set at run
//   time: 5..DATA_WIDTH data bits, optional even/odd parity, and 1 or 2 stop
//   bits. Each bit is the 3-sample majority taken around mid-bit. Finished
//   frames go out through a valid/ready output register. A frame that finishes
//   while that register is still full is dropped and reported.
//
// Optional feature (macro UART_RX_BREAK_DETECT_EN):
//   When defined, a frame whose data bits, parity bit (if present) and first
//   stop bit all sample 0 is treated as a line break. It pulses break_detected
//   and is not delivered. The receiver then waits for the line to return high.
//   When undefined, such a frame is delivered as data 0 with frame_error set,
//   and break_detected is tied to 0.
//
// Ports:
//   clk            oversampling system clock
//   reset          asynchronous active-low reset
//   serial_data    asynchronous serial line, idle high
//   prescale       clocks per bit: 8, 16 or 32 (any other value means 16)
//   data_length    data bits per frame, 5..DATA_WIDTH (out of range = DATA_WIDTH)
//   parity_enable  parity bit follows the data bits
//   parity_type    1 = odd parity, 0 = even parity
//   two_stop_bits  two stop bits expected
//   rx_ready       consumer accepts the presented frame this cycle
//   rx_data        received data, LSB-aligned, unused MSBs zero
//   rx_valid       rx_data and error flags are valid; held until accepted
//   parity_error   parity mismatch for the presented frame
//   frame_error    a stop bit sampled 0 for the presented frame
//   overrun_error  1-cycle pulse: a finished frame was dropped (output full)
//   break_detected 1-cycle pulse: line break seen
// -----------------------------------------------------------------------------
module uart_frame_receiver #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  serial_data,
   input  logic [5:0]            prescale,
   input  logic [3:0]            data_length,
   input  logic                  parity_enable,
   input  logic                  parity_type,
   input  logic                  two_stop_bits,
   input  logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  parity_error,
   output logic                  frame_error,
   output logic                  overrun_error,
   output logic                  break_detected
);

   localparam logic [3:0] LP_LEN_MAX = 4'(DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
`ifdef UART_RX_BREAK_DETECT_EN
      , S_WAIT_IDLE
`endif
   } t_state;

   t_state                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [5:0]             r_p;
   logic [5:0]             r_cnt;
   logic [3:0]             r_len;
   logic [3:0]             r_idx;
   logic                   r_par_en;
   logic                   r_par_type;
   logic                   r_two_stop;
   logic                   r_s0;
   logic                   r_s1;
   logic [DATA_WIDTH-1:0]  r_data;
   logic                   r_par;
   logic                   r_perr;
   logic                   r_ferr;
   logic [DATA_WIDTH-1:0]  r_rx_data;
   logic                   r_rx_valid;
   logic                   r_perr_o;
   logic                   r_ferr_o;
   logic                   r_overrun;
`ifdef UART_RX_BREAK_DETECT_EN
   logic                   r_all_zero;
   logic                   r_break;
`endif

   logic       w_sd;
   logic [5:0] w_p_in;
   logic [3:0] w_len_in;
   logic [5:0] w_half;
   logic       w_dec;
   logic       w_bit_end;
   logic       w_maj;
   logic       w_break;
   logic       w_complete;
   logic       w_load;
   logic       w_ferr_final;

   // Input synchroniser; flops reset to the idle-high line level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_sync <= '1;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], serial_data};
   end

   assign w_sd     = r_sync[SYNC_STAGES-1];
   assign w_p_in   = (prescale == 6'd8 || prescale == 6'd16 || prescale == 6'd32) ? prescale : 6'd16;
   assign w_len_in = (data_length >= 4'd5 && data_length <= LP_LEN_MAX) ? data_length : LP_LEN_MAX;

   // Samples at P/2-1 and P/2 are registered; the third sample is the live
   // bit at the decision count P/2+1.
   assign w_half    = {1'b0, r_p[5:1]};
   assign w_dec     = (r_cnt == w_half + 6'd1);
   assign w_bit_end = (r_cnt == r_p - 6'd1);
   assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_sd) | (r_s1 & w_sd);

`ifdef UART_RX_BREAK_DETECT_EN
   assign w_break = (r_state == S_STOP1) && w_dec && !w_maj && r_all_zero;
`else
   assign w_break = 1'b0;
`endif

   // The frame finishes at the decision point of its last stop bit.
   assign w_complete   = w_dec && !w_break &&
                         ((r_state == S_STOP1 && !r_two_stop) || r_state == S_STOP2);
   assign w_ferr_final = r_ferr | ~w_maj;
   assign w_load       = w_complete && (!r_rx_valid || rx_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_p        <= 6'd16;
         r_cnt      <= '0;
         r_len      <= LP_LEN_MAX;
         r_idx      <= '0;
         r_par_en   <= 1'b0;
         r_par_type <= 1'b0;
         r_two_stop <= 1'b0;
         r_s0       <= 1'b1;
         r_s1       <= 1'b1;
         r_data     <= '0;
         r_par      <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_perr_o   <= 1'b0;
         r_ferr_o   <= 1'b0;
         r_overrun  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         r_all_zero <= 1'b0;
         r_break    <= 1'b0;
`endif
      end else begin
         r_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         r_break   <= 1'b0;
`endif

         // Output register: a new frame may replace one being accepted this cycle.
         if (w_load) begin
            r_rx_data  <= r_data;
            r_perr_o   <= r_perr;
            r_ferr_o   <= w_ferr_final;
            r_rx_valid <= 1'b1;
         end else begin
            if (w_complete)              r_overrun  <= 1'b1;
            if (r_rx_valid && rx_ready)  r_rx_valid <= 1'b0;
         end

         if (r_cnt == w_half - 6'd1) r_s0 <= w_sd;
         if (r_cnt == w_half)        r_s1 <= w_sd;

         if (r_state != S_IDLE) r_cnt <= w_bit_end ? 6'd0 : r_cnt + 6'd1;

         case (r_state)
            S_IDLE: begin
               if (!w_sd) begin
                  r_state    <= S_START;
                  r_cnt      <= '0;
                  r_p        <= w_p_in;
                  r_len      <= w_len_in;
                  r_par_en   <= parity_enable;
                  r_par_type <= parity_type;
                  r_two_stop <= two_stop_bits;
                  r_data     <= '0;
                  r_par      <= 1'b0;
                  r_perr     <= 1'b0;
                  r_ferr     <= 1'b0;
                  r_idx      <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
                  r_all_zero <= 1'b1;
`endif
               end
            end
            S_START: begin
               // A start bit that votes high was a glitch: drop silently.
               if (w_dec && w_maj) r_state <= S_IDLE;
               else if (w_bit_end) r_state <= S_DATA;
            end
            S_DATA: begin
               if (w_dec) begin
                  for (int i = 0; i < DATA_WIDTH; i++)
                     if (r_idx == 4'(i)) r_data[i] <= w_maj;
                  r_par <= r_par ^ w_maj;
`ifdef UART_RX_BREAK_DETECT_EN
                  if (w_maj) r_all_zero <= 1'b0;
`endif
               end
               if (w_bit_end) begin
                  if (r_idx == r_len - 4'd1) r_state <= r_par_en ? S_PARITY : S_STOP1;
                  else                       r_idx   <= r_idx + 4'd1;
               end
            end
            S_PARITY: begin
               if (w_dec) begin
                  r_perr <= ((r_par ^ w_maj) != r_par_type);
`ifdef UART_RX_BREAK_DETECT_EN
                  if (w_maj) r_all_zero <= 1'b0;
`endif
               end
               if (w_bit_end) r_state <= S_STOP1;
            end
            S_STOP1: begin
               if (w_dec) begin
`ifdef UART_RX_BREAK_DETECT_EN
                  if (w_break) begin
                     r_state <= S_WAIT_IDLE;
                     r_break <= 1'b1;
                  end else
`endif
                  if (r_two_stop) r_ferr  <= w_ferr_final;
                  else            r_state <= S_IDLE;
               end else if (w_bit_end && r_two_stop) begin
                  r_state <= S_STOP2;
               end
            end
            S_STOP2: begin
               if (w_dec) r_state <= S_IDLE;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            S_WAIT_IDLE: begin
               // Stay here until a whole bit votes high, so the tail of the
               // break is not taken as a new start bit.
               if (w_dec && w_maj) r_state <= S_IDLE;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_data       = r_rx_data;
   assign rx_valid      = r_rx_valid;
   assign parity_error  = r_perr_o;
   assign frame_error   = r_ferr_o;
   assign overrun_error = r_overrun;
`ifdef UART_RX_BREAK_DETECT_EN
   assign break_detected = r_break;
`else
   assign break_detected = 1'b0;
`endif

endmodule
